// File: rtl/mem_wb_pkg.sv
// Shared MEM/WB types: write-back control bundle and the default-width pipeline beat.
package mem_wb_pkg;

    localparam int unsigned WB_CTRL_W        = 2;
    localparam int unsigned MEM_WB_DATA_W    = 32;
    localparam int unsigned MEM_WB_REG_ADDR_W = 4;

    typedef struct packed {
        logic reg_write_enable;
        logic mem_to_reg_select;
    } wb_ctrl_t;

    // Beat layout at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        wb_ctrl_t                       ctrl;
        logic [MEM_WB_DATA_W-1:0]       alu_result;
        logic [MEM_WB_DATA_W-1:0]       mem_data;
        logic [MEM_WB_REG_ADDR_W-1:0]   rd;
    } mem_wb_beat_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// One pipeline stage: main register plus a skid register, registered ready,
// synchronous flush and synchronous active-low reset.
module pipe_skid_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;
    logic             ready_q,   ready_d;
    logic             accept, consume;

    assign accept  = in_valid_i & ready_q;
    assign consume = m_valid_q & out_ready_i;

    // Skid drains into main before any new beat, so order is kept.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (!m_valid_q || consume) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_data_d = in_data_i;
                end
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data_i;
        end
        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            s_data_d  = '0;
        end
        ready_d = ~s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            ready_q   <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_data_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: STAGES chained skid stages, occupancy counter,
// write-back data mux and hazard-unit forwarding tap.
module mem_wb_pipe_reg
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned STAGES         = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               reg_write_enable_in,
    input  logic                               mem_to_reg_select_in,
    input  logic [DATA_WIDTH-1:0]              alu_result_in,
    input  logic [DATA_WIDTH-1:0]              mem_data_in,
    input  logic [REG_ADDR_WIDTH-1:0]          rd_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               reg_write_enable_out,
    output logic [REG_ADDR_WIDTH-1:0]          rd_out,
    output logic [DATA_WIDTH-1:0]              wb_data_out,
    output logic                               fwd_valid,
    output logic [$clog2(2*STAGES+1)-1:0]      occupancy
);

    localparam int unsigned OCC_W = $clog2(2*STAGES+1);
    localparam int unsigned PW    = WB_CTRL_W + 2*DATA_WIDTH + REG_ADDR_WIDTH;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("mem_wb_pipe_reg: STAGES must be in 1..4");
    end

    typedef struct packed {
        wb_ctrl_t                  ctrl;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     mem_data;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } beat_t;

    beat_t          in_beat, head;
    logic           vld [STAGES+1];
    logic           rdy [STAGES+1];
    logic [PW-1:0]  dat [STAGES+1];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic           accept, consume;

    always_comb begin
        in_beat.ctrl.reg_write_enable  = reg_write_enable_in;
        in_beat.ctrl.mem_to_reg_select = mem_to_reg_select_in;
        in_beat.alu_result             = alu_result_in;
        in_beat.mem_data               = mem_data_in;
        in_beat.rd                     = rd_in;
    end

    assign vld[0]      = in_valid;
    assign dat[0]      = in_beat;
    assign rdy[STAGES] = out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_skid_stage #(.WIDTH(PW)) u_stage (
            .clk         (clk),
            .rst_ni      (reset),
            .flush_i     (flush),
            .in_valid_i  (vld[g]),
            .in_ready_o  (rdy[g]),
            .in_data_i   (dat[g]),
            .out_valid_o (vld[g+1]),
            .out_ready_i (rdy[g+1]),
            .out_data_o  (dat[g+1])
        );
    end

    assign head     = dat[STAGES];
    assign in_ready = rdy[0];
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    // Beats held = accepted minus consumed; flush empties everything.
    always_comb begin
        occ_d = occ_q;
        if (accept && !consume) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept && consume) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy            = occ_q;
    assign out_valid            = vld[STAGES];
    assign reg_write_enable_out = out_valid & head.ctrl.reg_write_enable;
    assign fwd_valid            = reg_write_enable_out;
    assign rd_out               = head.rd;
    assign wb_data_out          = head.ctrl.mem_to_reg_select ? head.mem_data : head.alu_result;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg at STAGES=2: reset, streaming, backpressure,
// write-back mux, flush and mid-stall reset.
module tb_mem_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic        reg_write_enable_in, mem_to_reg_select_in;
    logic [31:0] alu_result_in, mem_data_in;
    logic [3:0]  rd_in;
    logic        out_valid, out_ready, reg_write_enable_out, fwd_valid;
    logic [3:0]  rd_out;
    logic [31:0] wb_data_out;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .STAGES(2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .reg_write_enable_in  (reg_write_enable_in),
        .mem_to_reg_select_in (mem_to_reg_select_in),
        .alu_result_in        (alu_result_in),
        .mem_data_in          (mem_data_in),
        .rd_in                (rd_in),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .reg_write_enable_out (reg_write_enable_out),
        .rd_out               (rd_out),
        .wb_data_out          (wb_data_out),
        .fwd_valid            (fwd_valid),
        .occupancy            (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic rwe, input logic m2r,
                            input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] rd);
        in_valid             = v;
        reg_write_enable_in  = rwe;
        mem_to_reg_select_in = m2r;
        alu_result_in        = alu;
        mem_data_in          = mem;
        rd_in                = rd;
    endtask

    initial begin
        int          seen;
        logic [31:0] seen_data;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // 1. reset held for 3 cycles, then released
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        step();
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_occ", 32'(occupancy), 32'd0);
        chk("rel_rwe", 32'(reg_write_enable_out), 32'd0);
        chk("rel_wb_data", wb_data_out, 32'd0);

        // 2. full-rate stream, beat w visible two windows after it is driven
        out_ready = 1'b1;
        for (int w = 0; w < 11; w++) begin
            if (w >= 2 && w < 10) begin
                chk("strm_valid", 32'(out_valid), 32'd1);
                chk("strm_wb", wb_data_out, 32'h10 + 32'(w - 2));
                chk("strm_rd", 32'(rd_out), 32'(w - 1));
            end else begin
                chk("strm_idle", 32'(out_valid), 32'd0);
            end
            if (w < 8) begin
                chk("strm_in_ready", 32'(in_ready), 32'd1);
                set_beat(1'b1, 1'b1, 1'b0, 32'h10 + 32'(w), 32'hFFFF_0000, 4'(w + 1));
            end else begin
                set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            step();
        end
        chk("strm_occ", 32'(occupancy), 32'd0);

        // 3. backpressure: four slots fill, then drain in order
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("bp_in_ready", 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
            set_beat(1'b1, 1'b1, 1'b0, 32'h20 + 32'(k), 32'h0, 4'(k + 9));
            step();
        end
        chk("bp_occ", 32'(occupancy), 32'd4);
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_wb", wb_data_out, 32'h20 + 32'(k));
            step();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        chk("drain_occ", 32'(occupancy), 32'd0);

        // 4. memory write-back select and forwarding tap
        set_beat(1'b1, 1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 4'd5);
        step();
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        chk("m2r_wb", wb_data_out, 32'hDEAD_BEEF);
        chk("m2r_rd", 32'(rd_out), 32'd5);
        chk("m2r_fwd", 32'(fwd_valid), 32'd1);
        chk("m2r_rwe", 32'(reg_write_enable_out), 32'd1);
        set_beat(1'b1, 1'b0, 1'b1, 32'h1, 32'hDEAD_BEEF, 4'd5);
        step();
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        chk("norwe_valid", 32'(out_valid), 32'd1);
        chk("norwe_wb", wb_data_out, 32'hDEAD_BEEF);
        chk("norwe_fwd", 32'(fwd_valid), 32'd0);
        chk("norwe_rwe", 32'(reg_write_enable_out), 32'd0);
        step();

        // 5. flush at occupancy 3 drops the offered beat too
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_beat(1'b1, 1'b1, 1'b0, 32'h30 + 32'(k), 32'h0, 4'd2);
            step();
        end
        chk("fl_occ_pre", 32'(occupancy), 32'd3);
        set_beat(1'b1, 1'b1, 1'b0, 32'hBAD, 32'h0, 4'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("fl_no_beat", 32'(out_valid), 32'd0);
            step();
        end

        // 6. reset mid-stall, then exactly one new beat emerges
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_beat(1'b1, 1'b1, 1'b0, 32'h40 + 32'(k), 32'h0, 4'd4);
            step();
        end
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("rs_occ_pre", 32'(occupancy), 32'd2);
        reset = 1'b0;
        step();
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_in_ready", 32'(in_ready), 32'd0);
        chk("rs_occ", 32'(occupancy), 32'd0);
        chk("rs_rwe", 32'(reg_write_enable_out), 32'd0);
        chk("rs_wb", wb_data_out, 32'd0);
        reset = 1'b1;
        step();
        chk("rs_rel_ready", 32'(in_ready), 32'd1);
        set_beat(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 4'd7);
        step();
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        out_ready = 1'b1;
        seen      = 0;
        seen_data = 32'h0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) begin
                if (seen == 0) seen_data = wb_data_out;
                seen++;
            end
            step();
        end
        chk("rs_beats", 32'(seen), 32'd1);
        chk("rs_data", seen_data, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
